// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and event bundle for the I2C subordinate front end
package i2c_pkg;

  localparam int I2C_FILT_LEN_DEF = 4;
  localparam int I2C_SYNC_DEF     = 2;

  typedef struct packed {
    logic start;
    logic rstart;
    logic stop;
    logic scl_rise;
    logic scl_fall;
  } i2c_evt_t;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - input synchronizer plus glitch filter for one I2C line
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN    = I2C_FILT_LEN_DEF,
  parameter int SYNC_STAGES = I2C_SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_filt
);

  localparam logic [3:0] LP_CNT_MAX = 4'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [3:0]             r_cnt;
  logic                   r_filt;
  logic                   w_s;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign o_filt = r_filt;

  // Idle bus is high, so everything resets to 1 to avoid phantom edges at release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
      if (w_s == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_CNT_MAX) begin
        r_filt <= w_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_start_stop_detect.sv
// rtl/i2c_start_stop_detect.sv - START/STOP/repeated-START and SCL edge strobes with bus-busy flag
module i2c_start_stop_detect
  import i2c_pkg::*;
#(
  parameter int FILT_LEN    = I2C_FILT_LEN_DEF,
  parameter int SYNC_STAGES = I2C_SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic rstart,
  output logic stop,
  output logic busy
);

  logic     w_scl_f;
  logic     w_sda_f;
  logic     r_p_scl;
  logic     r_p_sda;
  logic     r_busy;
  i2c_evt_t r_evt;
  i2c_evt_t w_evt;

  i2c_line_filter #(.FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES)) u_scl_filt (
    .clk   (clk),
    .rst   (rst),
    .i_line(scl_in),
    .o_filt(w_scl_f)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES)) u_sda_filt (
    .clk   (clk),
    .rst   (rst),
    .i_line(sda_in),
    .o_filt(w_sda_f)
  );

  // START/STOP require SCL high on both samples, so an SCL edge masks any SDA change.
  always_comb begin
    w_evt          = '0;
    w_evt.scl_rise = !r_p_scl & w_scl_f;
    w_evt.scl_fall = r_p_scl & !w_scl_f;
    w_evt.start    = r_p_scl & w_scl_f & r_p_sda & !w_sda_f;
    w_evt.stop     = r_p_scl & w_scl_f & !r_p_sda & w_sda_f;
    w_evt.rstart   = w_evt.start & r_busy;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_scl <= 1'b1;
      r_p_sda <= 1'b1;
      r_busy  <= 1'b0;
      r_evt   <= '0;
    end else begin
      r_p_scl <= w_scl_f;
      r_p_sda <= w_sda_f;
      r_evt   <= w_evt;
      if (w_evt.start) begin
        r_busy <= 1'b1;
      end else if (w_evt.stop) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign scl_f    = w_scl_f;
  assign sda_f    = w_sda_f;
  assign scl_rise = r_evt.scl_rise;
  assign scl_fall = r_evt.scl_fall;
  assign start    = r_evt.start;
  assign rstart   = r_evt.rstart;
  assign stop     = r_evt.stop;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_start_stop_detect.sv
// tb/tb_i2c_start_stop_detect.sv - self-checking bench for i2c_start_stop_detect
module tb_i2c_start_stop_detect;

  localparam int FL = 4;
  localparam int SS = 2;
  localparam int HL = SS + FL;

  logic clk = 1'b0;
  logic rst;
  logic scl_in;
  logic sda_in;
  logic scl_f, sda_f, scl_rise, scl_fall, start, rstart, stop, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [HL-1:0] m_scl_h, m_sda_h;
  logic m_scl_f1, m_scl_f2, m_sda_f1, m_sda_f2;
  logic m_busy, m_start, m_rstart, m_stop, m_rise, m_fall;

  int cnt_rise, cnt_fall, cnt_start, cnt_rstart, cnt_stop, cnt_co;
  int cyc_idx, t_start;

  i2c_start_stop_detect #(.FILT_LEN(FL), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .scl_f   (scl_f),
    .sda_f   (sda_f),
    .scl_rise(scl_rise),
    .scl_fall(scl_fall),
    .start   (start),
    .rstart  (rstart),
    .stop    (stop),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Filtered level = value of the line once it has been steady for FL synced samples.
  function automatic logic filt(input logic [HL-1:0] h, input logic cur);
    logic [FL-1:0] w;
    w = h[HL-1:SS];
    if (&w) return 1'b1;
    if (~|w) return 1'b0;
    return cur;
  endfunction

  task automatic model_reset();
    m_scl_h = '1; m_sda_h = '1;
    m_scl_f1 = 1'b1; m_scl_f2 = 1'b1; m_sda_f1 = 1'b1; m_sda_f2 = 1'b1;
    m_busy = 1'b0; m_start = 1'b0; m_rstart = 1'b0; m_stop = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic d);
    logic ns, nd;
    m_scl_h = {m_scl_h[HL-2:0], s};
    m_sda_h = {m_sda_h[HL-2:0], d};
    ns = filt(m_scl_h, m_scl_f1);
    nd = filt(m_sda_h, m_sda_f1);
    m_rise   = !m_scl_f2 && m_scl_f1;
    m_fall   = m_scl_f2 && !m_scl_f1;
    m_start  = m_scl_f2 && m_scl_f1 && m_sda_f2 && !m_sda_f1;
    m_stop   = m_scl_f2 && m_scl_f1 && !m_sda_f2 && m_sda_f1;
    m_rstart = m_start && m_busy;
    if (m_start) m_busy = 1'b1;
    else if (m_stop) m_busy = 1'b0;
    m_scl_f2 = m_scl_f1; m_scl_f1 = ns;
    m_sda_f2 = m_sda_f1; m_sda_f1 = nd;
  endtask

  task automatic compare();
    chk("scl_f", scl_f, m_scl_f1);
    chk("sda_f", sda_f, m_sda_f1);
    chk("scl_rise", scl_rise, m_rise);
    chk("scl_fall", scl_fall, m_fall);
    chk("start", start, m_start);
    chk("rstart", rstart, m_rstart);
    chk("stop", stop, m_stop);
    chk("busy", busy, m_busy);
  endtask

  task automatic clr_counts();
    cnt_rise = 0; cnt_fall = 0; cnt_start = 0; cnt_rstart = 0; cnt_stop = 0; cnt_co = 0;
    cyc_idx = 0; t_start = 0;
  endtask

  task automatic cyc(input logic s, input logic d);
    scl_in = s;
    sda_in = d;
    @(posedge clk);
    if (rst) model_edge(s, d);
    else model_reset();
    #1;
    compare();
    cyc_idx++;
    if (scl_rise) cnt_rise++;
    if (scl_fall) cnt_fall++;
    if (start) cnt_start++;
    if (rstart) cnt_rstart++;
    if (stop) cnt_stop++;
    if (start && rstart) cnt_co++;
    if (start && t_start == 0) t_start = cyc_idx;
  endtask

  task automatic hold(input int n, input logic s, input logic d);
    for (int i = 0; i < n; i++) cyc(s, d);
  endtask

  initial begin
    rst = 1'b0; scl_in = 1'b1; sda_in = 1'b1;
    model_reset();
    clr_counts();
    hold(3, 1'b1, 1'b1);
    rst = 1'b1;

    // START: latency from first sampling edge, single pulse, busy set
    hold(10, 1'b1, 1'b1);
    clr_counts();
    hold(12, 1'b1, 1'b0);
    chk("start_lat", t_start, 7);
    chk("start_cnt", cnt_start, 1);
    chk("start_rstart", cnt_rstart, 0);
    chk("start_busy", busy, 1);
    clr_counts();
    hold(12, 1'b1, 1'b1);
    chk("stop_cnt", cnt_stop, 1);
    chk("stop_busy", busy, 0);

    // Glitches of FL-1 cycles are swallowed, FL cycles pass
    clr_counts();
    hold(3, 1'b0, 1'b1);
    hold(10, 1'b1, 1'b1);
    hold(3, 1'b1, 1'b0);
    hold(10, 1'b1, 1'b1);
    chk("glitch_fall", cnt_fall, 0);
    chk("glitch_start", cnt_start, 0);
    hold(4, 1'b1, 1'b0);
    hold(10, 1'b1, 1'b1);
    chk("pulse4_start", cnt_start, 1);
    chk("pulse4_stop", cnt_stop, 1);
    clr_counts();
    hold(4, 1'b0, 1'b1);
    hold(10, 1'b1, 1'b1);
    chk("pulse4_fall", cnt_fall, 1);
    chk("pulse4_rise", cnt_rise, 1);

    // Repeated START after nine clock pulses
    hold(10, 1'b1, 1'b0);
    clr_counts();
    for (int i = 0; i < 9; i++) begin
      hold(10, 1'b0, 1'b0);
      hold(10, 1'b1, 1'b0);
    end
    chk("rs_rise9", cnt_rise, 9);
    chk("rs_fall9", cnt_fall, 9);
    hold(10, 1'b0, 1'b1);
    hold(10, 1'b1, 1'b1);
    clr_counts();
    hold(12, 1'b1, 1'b0);
    chk("rs_start", cnt_start, 1);
    chk("rs_coinc", cnt_co, 1);
    chk("rs_busy", busy, 1);

    // Simultaneous SCL/SDA change while busy
    hold(10, 1'b0, 1'b0);
    clr_counts();
    hold(12, 1'b1, 1'b1);
    chk("sim_rise", cnt_rise, 1);
    chk("sim_stop", cnt_stop, 0);
    chk("sim_busy", busy, 1);

    // Asynchronous reset mid-transfer with lines toggling
    for (int i = 0; i < 6; i++) cyc(1'(i % 2), 1'(i / 3));
    rst = 1'b0;
    #1;
    model_reset();
    compare();
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 5; i++) cyc(1'(i % 2), 1'((i + 1) % 2));
    hold(3, 1'b1, 1'b1);
    rst = 1'b1;
    clr_counts();
    hold(20, 1'b1, 1'b1);
    chk("rst_quiet", cnt_rise + cnt_fall + cnt_start + cnt_stop, 0);

    // Spurious STOP while idle
    hold(10, 1'b0, 1'b1);
    hold(10, 1'b1, 1'b0);
    clr_counts();
    hold(12, 1'b1, 1'b1);
    chk("idle_stop", cnt_stop, 1);
    chk("idle_busy", busy, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      hold($urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_start_stop_detect.md
Name: i2c_start_stop_detect

Overview:
- Front-end conditioning stage of the I2C subordinate interface. Sits directly upstream of the bit/clock counter and the shift logic.
- Synchronizes raw SCL/SDA pins into the system clock domain and removes glitches.
- Produces single-cycle START, STOP, repeated-START and SCL edge strobes plus a bus-busy level; downstream counting and data stages consume these.

Parameters:
- FILT_LEN, 4, consecutive clk cycles a synchronized line must hold a new value before the filtered value changes; legal range 1..15.
- SYNC_STAGES, 2, flops in each input synchronizer; legal range 2..3.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- scl_in  input  1  raw SCL pin, asynchronous to clk.
- sda_in  input  1  raw SDA pin, asynchronous to clk.
- scl_f  output  1  filtered SCL level.
- sda_f  output  1  filtered SDA level.
- scl_rise  output  1  one-cycle pulse on a filtered SCL 0->1 transition.
- scl_fall  output  1  one-cycle pulse on a filtered SCL 1->0 transition.
- start  output  1  one-cycle pulse on START or repeated START.
- rstart  output  1  one-cycle pulse on a START detected while busy=1; always coincident with start.
- stop  output  1  one-cycle pulse on STOP.
- busy  output  1  level: bus owned between START and STOP.

Behaviour:
- Reset (rst=0, asynchronous):
  - Synchronizer flops, scl_f and sda_f go to 1 (idle bus high).
  - Filter counters go to 0.
  - All pulse outputs and busy go to 0.
  - Applying reset mid-transfer drops busy immediately. No stop pulse is generated.
- Synchronizer: SYNC_STAGES flops per line; output is scl_s / sda_s.
- Filter, per line, independently:
  - If the synced value equals the filtered value, the counter clears to 0.
  - Otherwise the counter increments.
  - When counter==FILT_LEN-1 and the synced value still differs, the filtered value takes the synced value and the counter clears.
  - A pulse shorter than FILT_LEN cycles never reaches scl_f/sda_f.
  - The counter is 4 bits and never wraps, because it clears at FILT_LEN-1.
- Latency:
  - A raw change held stable appears on scl_f/sda_f SYNC_STAGES+FILT_LEN cycles after the first clk edge that samples it.
  - All strobes are registered and assert 1 cycle after the filtered change.
- Event decode uses previous filtered values p_scl/p_sda and current values scl_f/sda_f:
  - scl_rise = !p_scl & scl_f.
  - scl_fall = p_scl & !scl_f.
  - START = p_scl & scl_f & p_sda & !sda_f.
  - STOP = p_scl & scl_f & !p_sda & sda_f.
- Simultaneous SCL and SDA change in the same cycle:
  - No START or STOP.
  - The scl_rise or scl_fall strobe still fires.
  - SDA is treated as a data change.
- busy:
  - Set in the cycle start pulses.
  - Cleared in the cycle stop pulses.
  - STOP while busy=0 still pulses stop; busy stays 0.
- rstart = START & busy, evaluated with busy before its update.
- start and stop are mutually exclusive by construction, since SDA cannot both rise and fall.
- Downstream contract: start/stop are clk-synchronous pulses, never level-held.

Decomposition:
- Package i2c_pkg:
  - Constants I2C_FILT_LEN_DEF=4 and I2C_SYNC_DEF=2.
  - Typedef i2c_evt_t: packed struct {start, rstart, stop, scl_rise, scl_fall}, shared with downstream stages.
- Sub-module i2c_line_filter (synchronizer + glitch filter for one line), instantiated twice. Top level holds the previous-value registers, event decode and busy flag.

Test Plan:
- Reset: assert rst=0 mid-stream with lines toggling -> scl_f=sda_f=1, busy=0, no pulses; after release with lines idle high -> outputs stay quiet for 20 cycles.
- START then STOP (FILT_LEN=4, SYNC_STAGES=2), each line held ≥10 cycles:
  - SDA falls while SCL high -> start=1 for exactly one cycle, 7 cycles after the first sampling edge; busy=1 from that cycle; rstart=0.
  - SDA then rises while SCL high -> stop one cycle, busy=0.
- Glitch rejection: 3-cycle low pulse on SCL and a 3-cycle pulse on SDA while SCL high -> no scl_fall, no start, scl_f/sda_f unchanged; a 4-cycle pulse -> filtered change, and a start pulse if SDA dropped while SCL high.
- Repeated START: START, 9 SCL pulses of 20 cycles each (expect 9 scl_rise and 9 scl_fall), SCL high, then SDA high->low -> start=1 and rstart=1 in the same cycle; busy stays 1.
- Simultaneous edges: SCL and SDA raw change on the same clk edge -> scl_rise/scl_fall fires, start=stop=0, busy unchanged.
- Spurious STOP while idle: SDA 0->1 with SCL high and busy=0 -> stop pulses once, busy remains 0.
